cok_birimli_yurut_tamponu: RTL and testbench

Parametrised execute-stage completion buffer for the next-generation core. It accepts one micro-op per cycle from register read and dispatches it to one of BIRIM_SAYISI variable-latency functional units (ALU, AI unit, multiplier, …) over a valid/ready handshake. Results are collected out of order into a DERINLIK-entry circular buffer and retired in program order toward the memory stage and the register-read forwarding path. Flushes after a mispredict use a slot-generation (epoch) bit, so late results from squashed ops are discarded.

---
 rtl/cok_birimli_yurut_tamponu_if.sv | 57 +++++
 rtl/cok_birimli_yurut_tamponu.sv | 145 ++++++++++++++
 tb/tb_cok_birimli_yurut_tamponu.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cok_birimli_yurut_tamponu_if.sv
// Signal bundle of the execute-stage completion buffer: uop input, functional-unit
// dispatch/result lanes and the in-order retire port.
interface cok_birimli_yurut_tamponu_if #(
    parameter int VERI_BIT     = 32,
    parameter int YAZMAC_BIT   = 5,
    parameter int ETIKET_BIT   = 4,
    parameter int BIRIM_SAYISI = 2,
    parameter int DERINLIK     = 4
) ();
    localparam int BS_BIT   = (BIRIM_SAYISI > 1) ? $clog2(BIRIM_SAYISI) : 1;
    localparam int SIRA_BIT = $clog2(DERINLIK) + 1;
    localparam int DOL_BIT  = $clog2(DERINLIK) + 1;

    logic                             bosalt_i;
    logic                             giris_gecerli_i;
    logic                             giris_hazir_o;
    logic [BS_BIT:0]                  giris_birim_i;
    logic [ETIKET_BIT-1:0]            giris_etiket_i;
    logic [YAZMAC_BIT-1:0]            giris_adres_i;
    logic                             giris_yaz_i;
    logic [VERI_BIT-1:0]              giris_islec1_i;
    logic [VERI_BIT-1:0]              giris_islec2_i;
    logic                             duraklat_o;
    logic [BIRIM_SAYISI-1:0]          birim_gecerli_o;
    logic [BIRIM_SAYISI-1:0]          birim_hazir_i;
    logic [VERI_BIT-1:0]              birim_islec1_o;
    logic [VERI_BIT-1:0]              birim_islec2_o;
    logic [SIRA_BIT-1:0]              birim_sira_o;
    logic [BIRIM_SAYISI-1:0]          birim_sonuc_gecerli_i;
    logic [BIRIM_SAYISI*SIRA_BIT-1:0] birim_sonuc_sira_i;
    logic [BIRIM_SAYISI*VERI_BIT-1:0] birim_sonuc_i;
    logic                             cikis_duraklat_i;
    logic                             cikis_gecerli_o;
    logic                             cikis_yaz_o;
    logic [VERI_BIT-1:0]              cikis_veri_o;
    logic [YAZMAC_BIT-1:0]            cikis_adres_o;
    logic [ETIKET_BIT-1:0]            cikis_etiket_o;
    logic [DOL_BIT-1:0]               doluluk_o;

    modport slave (
        input  bosalt_i, giris_gecerli_i, giris_birim_i, giris_etiket_i, giris_adres_i,
               giris_yaz_i, giris_islec1_i, giris_islec2_i, birim_hazir_i,
               birim_sonuc_gecerli_i, birim_sonuc_sira_i, birim_sonuc_i, cikis_duraklat_i,
        output giris_hazir_o, duraklat_o, birim_gecerli_o, birim_islec1_o, birim_islec2_o,
               birim_sira_o, cikis_gecerli_o, cikis_yaz_o, cikis_veri_o, cikis_adres_o,
               cikis_etiket_o, doluluk_o
    );

    modport master (
        output bosalt_i, giris_gecerli_i, giris_birim_i, giris_etiket_i, giris_adres_i,
               giris_yaz_i, giris_islec1_i, giris_islec2_i, birim_hazir_i,
               birim_sonuc_gecerli_i, birim_sonuc_sira_i, birim_sonuc_i, cikis_duraklat_i,
        input  giris_hazir_o, duraklat_o, birim_gecerli_o, birim_islec1_o, birim_islec2_o,
               birim_sira_o, cikis_gecerli_o, cikis_yaz_o, cikis_veri_o, cikis_adres_o,
               cikis_etiket_o, doluluk_o
    );
endinterface

// File: rtl/cok_birimli_yurut_tamponu.sv
// Execute-stage completion buffer: dispatches uops to variable-latency units, gathers
// results out of order and retires them in program order; an epoch bit squashes stale results.
module cok_birimli_yurut_tamponu #(
    parameter int VERI_BIT     = 32,
    parameter int YAZMAC_BIT   = 5,
    parameter int ETIKET_BIT   = 4,
    parameter int BIRIM_SAYISI = 2,
    parameter int DERINLIK     = 4
) (
    input logic                        clk_i,
    input logic                        rstn_i,
    cok_birimli_yurut_tamponu_if.slave bus
);
    localparam int AW       = $clog2(DERINLIK);
    localparam int SIRA_BIT = AW + 1;

    logic [DERINLIK-1:0]   gecerli_q;
    logic [DERINLIK-1:0]   bitti_q;
    logic [DERINLIK-1:0]   yaz_q;
    logic [ETIKET_BIT-1:0] etiket_q [DERINLIK];
    logic [YAZMAC_BIT-1:0] adres_q  [DERINLIK];
    logic [VERI_BIT-1:0]   sonuc_q  [DERINLIK];
    logic [AW-1:0]         bas_q;
    logic [AW-1:0]         kuyruk_q;
    logic [AW:0]           sayac_q;
    logic                  donem_q;

    logic                  cikis_gecerli_q;
    logic                  cikis_yaz_q;
    logic [VERI_BIT-1:0]   cikis_veri_q;
    logic [YAZMAC_BIT-1:0] cikis_adres_q;
    logic [ETIKET_BIT-1:0] cikis_etiket_q;

    logic                    gecis;
    logic                    hedef_hazir;
    logic                    giris_hazir;
    logic                    kabul;
    logic                    emekli;
    logic [BIRIM_SAYISI-1:0] birim_gecerli;
    logic [SIRA_BIT-1:0]     sonuc_sira [BIRIM_SAYISI];
    logic [VERI_BIT-1:0]     sonuc_veri [BIRIM_SAYISI];

    // A unit number beyond the last unit means the operand already is the result.
    always_comb begin
        gecis         = int'(bus.giris_birim_i) >= BIRIM_SAYISI;
        hedef_hazir   = 1'b0;
        birim_gecerli = '0;
        for (int k = 0; k < BIRIM_SAYISI; k++) begin
            if (int'(bus.giris_birim_i) == k) begin
                hedef_hazir = bus.birim_hazir_i[k];
            end
        end
        giris_hazir = !bus.bosalt_i && (int'(sayac_q) < DERINLIK) && (gecis || hedef_hazir);
        kabul       = bus.giris_gecerli_i && giris_hazir;
        for (int k = 0; k < BIRIM_SAYISI; k++) begin
            birim_gecerli[k] = kabul && (int'(bus.giris_birim_i) == k);
        end
        emekli = gecerli_q[bas_q] && bitti_q[bas_q] && !bus.cikis_duraklat_i;
    end

    always_comb begin
        for (int k = 0; k < BIRIM_SAYISI; k++) begin
            sonuc_sira[k] = bus.birim_sonuc_sira_i[k*SIRA_BIT +: SIRA_BIT];
            sonuc_veri[k] = bus.birim_sonuc_i[k*VERI_BIT +: VERI_BIT];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            gecerli_q <= '0;
            bitti_q   <= '0;
            yaz_q     <= '0;
            for (int i = 0; i < DERINLIK; i++) begin
                etiket_q[i] <= '0;
                adres_q[i]  <= '0;
                sonuc_q[i]  <= '0;
            end
            bas_q           <= '0;
            kuyruk_q        <= '0;
            sayac_q         <= '0;
            donem_q         <= 1'b0;
            cikis_gecerli_q <= 1'b0;
            cikis_yaz_q     <= 1'b0;
            cikis_veri_q    <= '0;
            cikis_adres_q   <= '0;
            cikis_etiket_q  <= '0;
        end else if (bus.bosalt_i) begin
            gecerli_q       <= '0;
            bas_q           <= '0;
            kuyruk_q        <= '0;
            sayac_q         <= '0;
            donem_q         <= !donem_q;
            cikis_gecerli_q <= 1'b0;
        end else begin
            // Walk units high to low so the lowest-numbered unit wins a slot collision.
            for (int k = BIRIM_SAYISI - 1; k >= 0; k--) begin
                if (bus.birim_sonuc_gecerli_i[k] && (sonuc_sira[k][AW] == donem_q) &&
                    gecerli_q[sonuc_sira[k][AW-1:0]]) begin
                    bitti_q[sonuc_sira[k][AW-1:0]] <= 1'b1;
                    sonuc_q[sonuc_sira[k][AW-1:0]] <= sonuc_veri[k];
                end
            end

            if (emekli) begin
                cikis_gecerli_q   <= 1'b1;
                cikis_yaz_q       <= yaz_q[bas_q];
                cikis_veri_q      <= sonuc_q[bas_q];
                cikis_adres_q     <= adres_q[bas_q];
                cikis_etiket_q    <= etiket_q[bas_q];
                gecerli_q[bas_q]  <= 1'b0;
                bitti_q[bas_q]    <= 1'b0;
                bas_q             <= bas_q + AW'(1);
            end else if (!bus.cikis_duraklat_i) begin
                cikis_gecerli_q <= 1'b0;
            end

            if (kabul) begin
                gecerli_q[kuyruk_q] <= 1'b1;
                bitti_q[kuyruk_q]   <= gecis;
                yaz_q[kuyruk_q]     <= bus.giris_yaz_i;
                etiket_q[kuyruk_q]  <= bus.giris_etiket_i;
                adres_q[kuyruk_q]   <= bus.giris_adres_i;
                if (gecis) begin
                    sonuc_q[kuyruk_q] <= bus.giris_islec1_i;
                end
                kuyruk_q <= kuyruk_q + AW'(1);
            end

            sayac_q <= sayac_q + {{AW{1'b0}}, kabul} - {{AW{1'b0}}, emekli};
        end
    end

    assign bus.giris_hazir_o   = giris_hazir;
    assign bus.duraklat_o      = bus.giris_gecerli_i && !giris_hazir;
    assign bus.birim_gecerli_o = birim_gecerli;
    assign bus.birim_islec1_o  = bus.giris_islec1_i;
    assign bus.birim_islec2_o  = bus.giris_islec2_i;
    assign bus.birim_sira_o    = {donem_q, kuyruk_q};
    assign bus.cikis_gecerli_o = cikis_gecerli_q;
    assign bus.cikis_yaz_o     = cikis_yaz_q;
    assign bus.cikis_veri_o    = cikis_veri_q;
    assign bus.cikis_adres_o   = cikis_adres_q;
    assign bus.cikis_etiket_o  = cikis_etiket_q;
    assign bus.doluluk_o       = sayac_q;
endmodule

// File: tb/tb_cok_birimli_yurut_tamponu.sv
// Bench for the completion buffer: a queue-based program-order model checked every cycle,
// plus directed scenarios with hand-computed retire values and timings.
module tb_cok_birimli_yurut_tamponu;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    cok_birimli_yurut_tamponu_if bus();

    cok_birimli_yurut_tamponu dut (
        .clk_i (clk),
        .rstn_i(rstn),
        .bus   (bus.slave)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    typedef struct {
        int          slot;
        bit          done;
        logic [31:0] data;
        logic        yaz;
        logic [3:0]  tag;
        logic [4:0]  addr;
    } ent_t;

    ent_t        mq[$];
    int          allocCount = 0;
    logic        mEpoch     = 1'b0;
    bit          mValid     = 1'b0;
    logic        expCv, expCy;
    logic [31:0] expCd;
    logic [4:0]  expCa;
    logic [3:0]  expCt;

    // Model sees the inputs the next rising edge will see, checks the current outputs, then advances.
    always @(negedge clk) begin : compare
        bit          pass, hz, doRet;
        bit          taken [4];
        logic [1:0]  expBg;
        logic [2:0]  s;
        ent_t        e;

        pass  = int'(bus.giris_birim_i) >= 2;
        hz    = !bus.bosalt_i && (mq.size() < 4) && (pass || bus.birim_hazir_i[bus.giris_birim_i[0]]);
        expBg = (bus.giris_gecerli_i && hz && !pass) ? (2'b01 << bus.giris_birim_i[0]) : 2'b00;
        if (mValid) begin
            checkOutput("giris_hazir", 64'(bus.giris_hazir_o), 64'(hz));
            checkOutput("duraklat", 64'(bus.duraklat_o), 64'(bus.giris_gecerli_i && !hz));
            checkOutput("birim_gecerli", 64'(bus.birim_gecerli_o), 64'(expBg));
            checkOutput("birim_sira", 64'(bus.birim_sira_o), 64'({mEpoch, 2'(allocCount % 4)}));
            checkOutput("birim_islec1", 64'(bus.birim_islec1_o), 64'(bus.giris_islec1_i));
            checkOutput("birim_islec2", 64'(bus.birim_islec2_o), 64'(bus.giris_islec2_i));
            checkOutput("cikis_gecerli", 64'(bus.cikis_gecerli_o), 64'(expCv));
            checkOutput("cikis_yaz", 64'(bus.cikis_yaz_o), 64'(expCy));
            checkOutput("cikis_veri", 64'(bus.cikis_veri_o), 64'(expCd));
            checkOutput("cikis_adres", 64'(bus.cikis_adres_o), 64'(expCa));
            checkOutput("cikis_etiket", 64'(bus.cikis_etiket_o), 64'(expCt));
            checkOutput("doluluk", 64'(bus.doluluk_o), 64'(mq.size()));
        end

        if (!rstn) begin
            mq.delete();
            allocCount = 0;
            mEpoch     = 1'b0;
            mValid     = 1'b1;
            expCv = 1'b0; expCy = 1'b0; expCd = '0; expCa = '0; expCt = '0;
        end else if (!mValid) begin
            mValid = 1'b0;
        end else if (bus.bosalt_i) begin
            mq.delete();
            allocCount = 0;
            mEpoch     = !mEpoch;
            expCv      = 1'b0;
        end else begin
            doRet = (mq.size() > 0) && mq[0].done && !bus.cikis_duraklat_i;
            for (int i = 0; i < 4; i++) taken[i] = 1'b0;
            for (int k = 0; k < 2; k++) begin
                if (bus.birim_sonuc_gecerli_i[k]) begin
                    s = bus.birim_sonuc_sira_i[k*3 +: 3];
                    if (s[2] == mEpoch && !taken[s[1:0]]) begin
                        for (int i = 0; i < mq.size(); i++) begin
                            if (mq[i].slot == int'(s[1:0])) begin
                                e      = mq[i];
                                e.done = 1'b1;
                                e.data = bus.birim_sonuc_i[k*32 +: 32];
                                mq[i]  = e;
                                taken[s[1:0]] = 1'b1;
                            end
                        end
                    end
                end
            end
            if (doRet) begin
                e     = mq.pop_front();
                expCv = 1'b1; expCy = e.yaz; expCd = e.data; expCa = e.addr; expCt = e.tag;
            end else if (!bus.cikis_duraklat_i) begin
                expCv = 1'b0;
            end
            if (bus.giris_gecerli_i && hz) begin
                e.slot = allocCount % 4;
                e.done = pass;
                e.data = pass ? bus.giris_islec1_i : 32'h0;
                e.yaz  = bus.giris_yaz_i;
                e.tag  = bus.giris_etiket_i;
                e.addr = bus.giris_adres_i;
                mq.push_back(e);
                allocCount++;
            end
        end
    end

    task automatic applyStimulus();
        @(posedge clk);
        #1;
        bus.giris_gecerli_i       = 1'b0;
        bus.birim_sonuc_gecerli_i = '0;
        bus.bosalt_i              = 1'b0;
    endtask

    task automatic setUop(input logic [1:0] birim, input logic [3:0] tag, input logic [4:0] addr,
                          input logic yaz, input logic [31:0] a, input logic [31:0] b);
        bus.giris_gecerli_i = 1'b1;
        bus.giris_birim_i   = birim;
        bus.giris_etiket_i  = tag;
        bus.giris_adres_i   = addr;
        bus.giris_yaz_i     = yaz;
        bus.giris_islec1_i  = a;
        bus.giris_islec2_i  = b;
    endtask

    task automatic setResult(input int k, input logic [2:0] sira, input logic [31:0] data);
        bus.birim_sonuc_gecerli_i[k]      = 1'b1;
        bus.birim_sonuc_sira_i[k*3 +: 3]  = sira;
        bus.birim_sonuc_i[k*32 +: 32]     = data;
    endtask

    task automatic doReset();
        rstn = 1'b0;
        applyStimulus();
        applyStimulus();
        rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0;
        bus.bosalt_i = 1'b0; bus.giris_gecerli_i = 1'b0; bus.giris_birim_i = '0;
        bus.giris_etiket_i = '0; bus.giris_adres_i = '0; bus.giris_yaz_i = 1'b0;
        bus.giris_islec1_i = '0; bus.giris_islec2_i = '0; bus.birim_hazir_i = 2'b11;
        bus.birim_sonuc_gecerli_i = '0; bus.birim_sonuc_sira_i = '0; bus.birim_sonuc_i = '0;
        bus.cikis_duraklat_i = 1'b0;

        // Reset values and back-to-back pass-through
        doReset();
        checkOutput("reset cikis_gecerli", 64'(bus.cikis_gecerli_o), 64'd0);
        checkOutput("reset cikis_veri", 64'(bus.cikis_veri_o), 64'd0);
        checkOutput("reset doluluk", 64'(bus.doluluk_o), 64'd0);
        setUop(2'd2, 4'd1, 5'd1, 1'b1, 32'h11, 32'h0); applyStimulus();
        setUop(2'd2, 4'd2, 5'd2, 1'b1, 32'h22, 32'h0); applyStimulus();
        checkOutput("pt1 gecerli", 64'(bus.cikis_gecerli_o), 64'd1);
        checkOutput("pt1 veri", 64'(bus.cikis_veri_o), 64'h11);
        checkOutput("pt1 etiket", 64'(bus.cikis_etiket_o), 64'd1);
        checkOutput("pt doluluk", 64'(bus.doluluk_o), 64'd1);
        setUop(2'd2, 4'd3, 5'd3, 1'b1, 32'h33, 32'h0); applyStimulus();
        checkOutput("pt2 veri", 64'(bus.cikis_veri_o), 64'h22);
        applyStimulus();
        checkOutput("pt3 veri", 64'(bus.cikis_veri_o), 64'h33);
        checkOutput("pt3 etiket", 64'(bus.cikis_etiket_o), 64'd3);
        applyStimulus();
        checkOutput("pt end gecerli", 64'(bus.cikis_gecerli_o), 64'd0);
        checkOutput("pt end doluluk", 64'(bus.doluluk_o), 64'd0);

        // Out-of-order completion retires in order
        doReset();
        setUop(2'd0, 4'd4, 5'd5, 1'b1, 32'h1, 32'h2); applyStimulus();
        setUop(2'd1, 4'd5, 5'd6, 1'b1, 32'h3, 32'h4); applyStimulus();
        setResult(1, 3'b001, 32'hBB); applyStimulus();
        applyStimulus();
        applyStimulus();
        checkOutput("ooo early gecerli", 64'(bus.cikis_gecerli_o), 64'd0);
        setResult(0, 3'b000, 32'hAA); applyStimulus();
        checkOutput("ooo wait gecerli", 64'(bus.cikis_gecerli_o), 64'd0);
        applyStimulus();
        checkOutput("ooo A veri", 64'(bus.cikis_veri_o), 64'hAA);
        checkOutput("ooo A adres", 64'(bus.cikis_adres_o), 64'd5);
        applyStimulus();
        checkOutput("ooo B veri", 64'(bus.cikis_veri_o), 64'hBB);
        checkOutput("ooo B etiket", 64'(bus.cikis_etiket_o), 64'd5);

        // Full buffer backpressure
        doReset();
        for (int i = 0; i < 4; i++) begin
            setUop(2'd0, 4'(i), 5'(i), 1'b1, 32'(i), 32'h0);
            applyStimulus();
        end
        setUop(2'd0, 4'd9, 5'd9, 1'b1, 32'h99, 32'h0); #1;
        checkOutput("full hazir", 64'(bus.giris_hazir_o), 64'd0);
        checkOutput("full duraklat", 64'(bus.duraklat_o), 64'd1);
        checkOutput("full doluluk", 64'(bus.doluluk_o), 64'd4);
        applyStimulus();
        setUop(2'd0, 4'd9, 5'd9, 1'b1, 32'h99, 32'h0);
        setResult(0, 3'b000, 32'h77); #1;
        checkOutput("full result-cycle hazir", 64'(bus.giris_hazir_o), 64'd0);
        applyStimulus();
        setUop(2'd0, 4'd9, 5'd9, 1'b1, 32'h99, 32'h0); #1;
        checkOutput("full retire-cycle hazir", 64'(bus.giris_hazir_o), 64'd0);
        applyStimulus();
        setUop(2'd0, 4'd9, 5'd9, 1'b1, 32'h99, 32'h0); #1;
        checkOutput("full retire veri", 64'(bus.cikis_veri_o), 64'h77);
        checkOutput("full reopen hazir", 64'(bus.giris_hazir_o), 64'd1);
        checkOutput("full reopen sira", 64'(bus.birim_sira_o), 64'd0);
        applyStimulus();

        // Reset mid-operation; a late result for an old slot is ignored
        doReset();
        setResult(0, 3'b001, 32'h12); applyStimulus();
        applyStimulus();
        checkOutput("midreset gecerli", 64'(bus.cikis_gecerli_o), 64'd0);
        checkOutput("midreset doluluk", 64'(bus.doluluk_o), 64'd0);

        // Downstream stall holds the retire port
        doReset();
        setUop(2'd2, 4'd1, 5'd1, 1'b1, 32'h41, 32'h0); applyStimulus();
        setUop(2'd2, 4'd2, 5'd2, 1'b0, 32'h42, 32'h0); applyStimulus();
        bus.cikis_duraklat_i = 1'b1;
        checkOutput("stall first veri", 64'(bus.cikis_veri_o), 64'h41);
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("stall held veri", 64'(bus.cikis_veri_o), 64'h41);
            checkOutput("stall held gecerli", 64'(bus.cikis_gecerli_o), 64'd1);
            checkOutput("stall held doluluk", 64'(bus.doluluk_o), 64'd1);
        end
        bus.cikis_duraklat_i = 1'b0;
        applyStimulus();
        checkOutput("stall release veri", 64'(bus.cikis_veri_o), 64'h42);
        checkOutput("stall release yaz", 64'(bus.cikis_yaz_o), 64'd0);
        applyStimulus();
        checkOutput("stall drain gecerli", 64'(bus.cikis_gecerli_o), 64'd0);

        // Flush squashes in-flight ops; stale-epoch result dropped
        doReset();
        setUop(2'd0, 4'd1, 5'd1, 1'b1, 32'h0, 32'h0); applyStimulus();
        setUop(2'd0, 4'd2, 5'd2, 1'b1, 32'h0, 32'h0); applyStimulus();
        bus.bosalt_i = 1'b1;
        setUop(2'd2, 4'd8, 5'd8, 1'b1, 32'h99, 32'h0); #1;
        checkOutput("flush hazir", 64'(bus.giris_hazir_o), 64'd0);
        applyStimulus();
        checkOutput("flush doluluk", 64'(bus.doluluk_o), 64'd0);
        setUop(2'd1, 4'd7, 5'd7, 1'b1, 32'h0, 32'h0); #1;
        checkOutput("flush new sira", 64'(bus.birim_sira_o), 64'b100);
        checkOutput("flush new birim_gecerli", 64'(bus.birim_gecerli_o), 64'b10);
        applyStimulus();
        setResult(0, 3'b000, 32'hDEAD); applyStimulus();
        setResult(1, 3'b100, 32'h5);
        checkOutput("flush stale gecerli", 64'(bus.cikis_gecerli_o), 64'd0);
        applyStimulus();
        checkOutput("flush stale2 gecerli", 64'(bus.cikis_gecerli_o), 64'd0);
        applyStimulus();
        checkOutput("flush good veri", 64'(bus.cikis_veri_o), 64'h5);
        checkOutput("flush good etiket", 64'(bus.cikis_etiket_o), 64'd7);
        applyStimulus();
        checkOutput("flush after gecerli", 64'(bus.cikis_gecerli_o), 64'd0);

        // Simultaneous results from both units
        doReset();
        setUop(2'd0, 4'd1, 5'd1, 1'b1, 32'h0, 32'h0); applyStimulus();
        setUop(2'd1, 4'd2, 5'd2, 1'b1, 32'h0, 32'h0); applyStimulus();
        setResult(0, 3'b000, 32'h60);
        setResult(1, 3'b001, 32'h61);
        applyStimulus();
        applyStimulus();
        checkOutput("dual first veri", 64'(bus.cikis_veri_o), 64'h60);
        applyStimulus();
        checkOutput("dual second veri", 64'(bus.cikis_veri_o), 64'h61);
        checkOutput("dual second etiket", 64'(bus.cikis_etiket_o), 64'd2);
        applyStimulus();
        checkOutput("dual drain gecerli", 64'(bus.cikis_gecerli_o), 64'd0);

        applyStimulus();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
